// File: rtl/aes_round_seq_if.sv
// Block-level valid/ready handshake between the AES sequencer and its producer/consumer.
// master: the side presenting blocks and taking ciphertext; slave: the sequencer.
interface aes_round_seq_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/aes_round_seq.sv
// Iterative AES-128 round sequencer: steps one block at a time through
// IDLE -> LOAD -> ROUND x NUM_ROUNDS -> DONE, driving the load/enable controls of
// the shared state/key round registers and the key-expansion Rcon.
// Optional feature: define AES_ROUND_SEQ_ABORT_EN to add an abort input that
// returns the sequencer to IDLE from any busy state without completing the block.
module aes_round_seq #(
    parameter int          NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_seq_if.slave   bus,
`ifdef AES_ROUND_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             ld_init,
    output logic             round_en,
    output logic             last_round,
    output logic [3:0]       round_idx,
    output logic [7:0]       rcon,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    state_t             state_q, state_d;
    logic               ld_init_q, ld_init_d;
    logic               round_en_q, round_en_d;
    logic               last_round_q, last_round_d;
    logic [3:0]         round_idx_q, round_idx_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               abort_w;

`ifdef AES_ROUND_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // GF(2^8) doubling with the AES polynomial; produces the next round's Rcon
    function automatic logic [7:0] rcon_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Next-state and next-output decode; every control output is registered
    always_comb begin
        state_d      = state_q;
        ld_init_d    = 1'b0;
        round_en_d   = 1'b0;
        last_round_d = 1'b0;
        round_idx_d  = round_idx_q;
        rcon_d       = rcon_q;
        out_valid_d  = out_valid_q;
        blk_cnt_d    = blk_cnt_q;

        unique case (state_q)
            IDLE: begin
                round_idx_d = 4'd0;
                out_valid_d = 1'b0;
                // abort takes priority over a new block arriving
                if (bus.in_valid && !abort_w) begin
                    state_d     = LOAD;
                    ld_init_d   = 1'b1;
                    rcon_d      = RCON_INIT;
                end
            end
            LOAD: begin
                // round 1 reuses the initial Rcon; it advances only from ROUND onwards
                state_d      = ROUND;
                round_en_d   = 1'b1;
                round_idx_d  = 4'd1;
                last_round_d = (LAST_IDX == 4'd1);
            end
            ROUND: begin
                rcon_d = rcon_next(rcon_q);
                if (round_idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    round_idx_d = 4'd0;
                end else begin
                    round_en_d   = 1'b1;
                    round_idx_d  = round_idx_q + 4'd1;
                    last_round_d = ((round_idx_q + 4'd1) == LAST_IDX);
                end
            end
            DONE: begin
                // hold ciphertext (no enables) until the consumer takes it
                out_valid_d = 1'b1;
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    rcon_d      = RCON_INIT;
                    blk_cnt_d   = blk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort drops the in-flight block; the completed-block count is left alone
        if (abort_w && (state_q != IDLE)) begin
            state_d      = IDLE;
            ld_init_d    = 1'b0;
            round_en_d   = 1'b0;
            last_round_d = 1'b0;
            out_valid_d  = 1'b0;
            round_idx_d  = 4'd0;
            rcon_d       = RCON_INIT;
            blk_cnt_d    = blk_cnt_q;
        end
    end

    // State and registered outputs; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ld_init_q    <= 1'b0;
            round_en_q   <= 1'b0;
            last_round_q <= 1'b0;
            round_idx_q  <= 4'd0;
            rcon_q       <= RCON_INIT;
            out_valid_q  <= 1'b0;
            blk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ld_init_q    <= ld_init_d;
            round_en_q   <= round_en_d;
            last_round_q <= last_round_d;
            round_idx_q  <= round_idx_d;
            rcon_q       <= rcon_d;
            out_valid_q  <= out_valid_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != IDLE);
    assign ld_init       = ld_init_q;
    assign round_en      = round_en_q;
    assign last_round    = last_round_q;
    assign round_idx     = round_idx_q;
    assign rcon          = rcon_q;
    assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq (NUM_ROUNDS=10, CNT_W=2 so counter wrap is reachable).
// Build with AES_ROUND_SEQ_ABORT_EN defined to also exercise the abort input.
module tb_aes_round_seq;
    localparam int CNT_W = 2;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       ld;
        logic       re;
        logic       lr;
        logic [3:0] idx;
        logic [7:0] rc;
        logic       ov;
        logic       ir;
        logic       bsy;
        logic       chk_rc;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             ld_init;
    logic             round_en;
    logic             last_round;
    logic [3:0]       round_idx;
    logic [7:0]       rcon;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;
`ifdef AES_ROUND_SEQ_ABORT_EN
    logic             abort;
`endif

    int               n_cmp;
    int               n_err;
    logic [CNT_W-1:0] exp_cnt;
    logic [7:0]       rcon_tab [10];
    logic [1:0]       cnt_tab [5];
    vec_t             vecs [13];

    aes_round_seq_if bus ();

    aes_round_seq #(
        .NUM_ROUNDS (10),
        .RCON_INIT  (8'h01),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef AES_ROUND_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .ld_init    (ld_init),
        .round_en   (round_en),
        .last_round (last_round),
        .round_idx  (round_idx),
        .rcon       (rcon),
        .busy       (busy),
        .blk_cnt    (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one clock and sample 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input int bound);
        for (int i = 0; i < bound && !bus.out_valid; i++) step();
        check("out_valid_wait", {31'd0, bus.out_valid}, 32'd1);
    endtask

    // one full block with immediate consumer acceptance
    task automatic run_block();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out_valid(20);
        step();
        exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_cnt = '0;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        cnt_tab  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // expected cycle-by-cycle trace from T0+1 (LOAD) to T0+13 (back in IDLE)
        vecs[0] = '{iv:0, ordy:1, ld:1, re:0, lr:0, idx:4'd0, rc:8'h01, ov:0, ir:0, bsy:1, chk_rc:1};
        for (int k = 1; k <= 10; k++)
            vecs[k] = '{iv:0, ordy:1, ld:0, re:1, lr:(k == 10), idx:4'(k), rc:rcon_tab[k-1],
                        ov:0, ir:0, bsy:1, chk_rc:1};
        vecs[11] = '{iv:0, ordy:1, ld:0, re:0, lr:0, idx:4'd0, rc:8'h00, ov:1, ir:0, bsy:1, chk_rc:0};
        vecs[12] = '{iv:0, ordy:1, ld:0, re:0, lr:0, idx:4'd0, rc:8'h00, ov:0, ir:1, bsy:0, chk_rc:0};

        // reset held two cycles with in_valid asserted
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
`ifdef AES_ROUND_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        step();
        step();
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_ld_init",   {31'd0, ld_init},       32'd0);
        check("rst_round_en",  {31'd0, round_en},      32'd0);
        check("rst_rcon",      {24'd0, rcon},          32'h01);
        check("rst_blk_cnt",   {30'd0, blk_cnt},       32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // single block, table-driven trace
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        for (int k = 0; k < 13; k++) begin
            check($sformatf("t2_ld_init[%0d]", k),    {31'd0, ld_init},       {31'd0, vecs[k].ld});
            check($sformatf("t2_round_en[%0d]", k),   {31'd0, round_en},      {31'd0, vecs[k].re});
            check($sformatf("t2_last_round[%0d]", k), {31'd0, last_round},    {31'd0, vecs[k].lr});
            check($sformatf("t2_out_valid[%0d]", k),  {31'd0, bus.out_valid}, {31'd0, vecs[k].ov});
            check($sformatf("t2_in_ready[%0d]", k),   {31'd0, bus.in_ready},  {31'd0, vecs[k].ir});
            check($sformatf("t2_busy[%0d]", k),       {31'd0, busy},          {31'd0, vecs[k].bsy});
            if (vecs[k].chk_rc) begin
                check($sformatf("t2_round_idx[%0d]", k), {28'd0, round_idx}, {28'd0, vecs[k].idx});
                check($sformatf("t2_rcon[%0d]", k),      {24'd0, rcon},      {24'd0, vecs[k].rc});
            end
            bus.in_valid  = vecs[k].iv;
            bus.out_ready = vecs[k].ordy;
            if (k < 12) step();
        end
        exp_cnt = exp_cnt + 1'b1;
        check("t2_blk_cnt", {30'd0, blk_cnt}, {30'd0, exp_cnt});

        // consumer stalls five cycles in DONE
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out_valid(20);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_out_valid[%0d]", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("t3_round_en[%0d]", i),  {31'd0, round_en},      32'd0);
            check($sformatf("t3_busy[%0d]", i),      {31'd0, busy},          32'd1);
            check($sformatf("t3_blk_cnt[%0d]", i),   {30'd0, blk_cnt},       {30'd0, exp_cnt});
            if (i == 5) bus.out_ready = 1'b1;
            step();
        end
        exp_cnt = exp_cnt + 1'b1;
        check("t3_out_valid_after", {31'd0, bus.out_valid}, 32'd0);
        check("t3_blk_cnt_after",   {30'd0, blk_cnt},       {30'd0, exp_cnt});

        // back-to-back: in_valid held high, accept every 13 cycles
        begin
            int ld_cyc [3];
            int n_ld;
            n_ld = 0;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                step();
                if (ld_init && n_ld < 3) begin
                    ld_cyc[n_ld] = c;
                    n_ld++;
                end
                if (ld_init || round_en || bus.out_valid)
                    check($sformatf("t4_in_ready[%0d]", c), {31'd0, bus.in_ready}, 32'd0);
                check($sformatf("t4_ld_re_excl[%0d]", c), {31'd0, ld_init & round_en}, 32'd0);
                check($sformatf("t4_ov_re_excl[%0d]", c), {31'd0, bus.out_valid & round_en}, 32'd0);
            end
            bus.in_valid = 1'b0;
            check("t4_num_loads", n_ld, 3);
            check("t4_first_load", ld_cyc[0], 1);
            check("t4_interval0", ld_cyc[1] - ld_cyc[0], 13);
            check("t4_interval1", ld_cyc[2] - ld_cyc[1], 13);
            for (int i = 0; i < 20 && busy; i++) step();
            check("t4_idle", {31'd0, busy}, 32'd0);
            exp_cnt = exp_cnt + 2'd3;
            check("t4_blk_cnt", {30'd0, blk_cnt}, {30'd0, exp_cnt});
        end

`ifdef AES_ROUND_SEQ_ABORT_EN
        // abort during round 4, then a clean block afterwards
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && round_idx != 4'd4; i++) step();
        check("t5_reach_round4", {28'd0, round_idx}, 32'd4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_busy",      {31'd0, busy},          32'd0);
        check("t5_round_en",  {31'd0, round_en},      32'd0);
        check("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t5_rcon",      {24'd0, rcon},          32'h01);
        check("t5_blk_cnt",   {30'd0, blk_cnt},       {30'd0, exp_cnt});
        for (int i = 0; i < 14; i++) begin
            step();
            check($sformatf("t5_no_ov[%0d]", i), {31'd0, bus.out_valid}, 32'd0);
        end
        // abort in IDLE wins over in_valid
        abort = 1'b1;
        bus.in_valid = 1'b1;
        step();
        check("t5_abort_idle_busy", {31'd0, busy}, 32'd0);
        abort = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5 && !round_en; i++) step();
        for (int r = 0; r < 10; r++) begin
            check($sformatf("t5_rcon[%0d]", r), {24'd0, rcon}, {24'd0, rcon_tab[r]});
            check($sformatf("t5_idx[%0d]", r),  {28'd0, round_idx}, r + 1);
            step();
        end
        wait_out_valid(5);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("t5_blk_cnt_after", {30'd0, blk_cnt}, {30'd0, exp_cnt});
`endif

        // fresh reset, five blocks to wrap the 2-bit counter
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
        check("t6_blk_cnt_rst", {30'd0, blk_cnt}, 32'd0);
        for (int b = 0; b < 5; b++) begin
            run_block();
            check($sformatf("t6_blk_cnt[%0d]", b), {30'd0, blk_cnt}, {30'd0, cnt_tab[b]});
        end

        // reset during round 7 drops the block
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && round_idx != 4'd7; i++) step();
        check("t6_reach_round7", {28'd0, round_idx}, 32'd7);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_rst_busy",     {31'd0, busy},         32'd0);
        check("t6_rst_round_en", {31'd0, round_en},     32'd0);
        check("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t6_rst_blk_cnt",  {30'd0, blk_cnt},      32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("t6_no_ov[%0d]", i), {31'd0, bus.out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
